symbol_deserializer: RTL and testbench



---
 rtl/symbol_deserializer_if.sv | 24 ++
 rtl/symbol_deserializer.sv | 88 ++++++++
 tb/tb_symbol_deserializer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/symbol_deserializer_if.sv
// Symbol-in / block-out bundle between demodulator, deserializer and AES decryptor.
// The deserializer uses the slave modport; the driving environment uses master.
interface symbol_deserializer_if;
    logic [1:0]   sym_data;
    logic         sym_valid;
    logic         sym_sof;
    logic [127:0] cipher_data;
    logic         block_valid;
    logic         dec_ready;
    logic [5:0]   sym_cnt;
    logic         overflow;
    logic         sync_err;
    logic [7:0]   drop_cnt;

    modport master (
        output sym_data, sym_valid, sym_sof, dec_ready,
        input  cipher_data, block_valid, sym_cnt, overflow, sync_err, drop_cnt
    );

    modport slave (
        input  sym_data, sym_valid, sym_sof, dec_ready,
        output cipher_data, block_valid, sym_cnt, overflow, sync_err, drop_cnt
    );
endinterface

// File: rtl/symbol_deserializer.sv
// Packs MSB-first 2-bit QPSK symbols into 128-bit cipher blocks and hands them
// to the decryptor through a one-block output buffer.
module symbol_deserializer (
    input  logic                  clk,
    input  logic                  reset,
    symbol_deserializer_if.slave  bus
);
    typedef enum logic {ASM_IDLE, ASM_COLLECT} asm_state_t;
    typedef enum logic {BUF_EMPTY, BUF_FULL}   buf_state_t;

    asm_state_t   asm_state_reg, asm_state_next;
    buf_state_t   buf_state_reg, buf_state_next;

    // Only the low 126 accumulator bits can ever reach a completed block.
    logic [125:0] acc_reg;
    logic [5:0]   cnt_reg;
    logic [127:0] cipher_reg;
    logic         overflow_reg;
    logic         sync_err_reg;
    logic [7:0]   drop_reg;

    logic sof_sym, data_sym, last_sym, consume, load, drop;

    assign sof_sym  = bus.sym_valid & bus.sym_sof;
    assign data_sym = bus.sym_valid & ~bus.sym_sof;
    assign last_sym = data_sym & (cnt_reg == 6'd63);
    assign consume  = (buf_state_reg == BUF_FULL) & bus.dec_ready;
    assign load     = last_sym & ((buf_state_reg == BUF_EMPTY) | bus.dec_ready);
    assign drop     = last_sym & ~load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asm_state_reg <= ASM_IDLE;
            buf_state_reg <= BUF_EMPTY;
        end else begin
            asm_state_reg <= asm_state_next;
            buf_state_reg <= buf_state_next;
        end
    end

    always_comb begin
        asm_state_next = asm_state_reg;
        if (sof_sym)
            asm_state_next = ASM_COLLECT;
        else if (data_sym)
            asm_state_next = last_sym ? ASM_IDLE : ASM_COLLECT;

        buf_state_next = buf_state_reg;
        if (load)
            buf_state_next = BUF_FULL;
        else if (consume)
            buf_state_next = BUF_EMPTY;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg      <= '0;
            cnt_reg      <= '0;
            cipher_reg   <= '0;
            overflow_reg <= 1'b0;
            sync_err_reg <= 1'b0;
            drop_reg     <= '0;
        end else begin
            overflow_reg <= drop;
            sync_err_reg <= sof_sym & (asm_state_reg == ASM_COLLECT);
            if (sof_sym) begin
                acc_reg <= {124'b0, bus.sym_data};
                cnt_reg <= 6'd1;
            end else if (data_sym) begin
                acc_reg <= {acc_reg[123:0], bus.sym_data};
                cnt_reg <= cnt_reg + 6'd1;   // 63 wraps to 0 on completion
            end
            if (load)
                cipher_reg <= {acc_reg, bus.sym_data};
            if (drop && drop_reg != 8'hFF)
                drop_reg <= drop_reg + 8'd1;
        end
    end

    always_comb begin
        bus.block_valid = (buf_state_reg == BUF_FULL);
        bus.cipher_data = cipher_reg;
        bus.sym_cnt     = cnt_reg;
        bus.overflow    = overflow_reg;
        bus.sync_err    = sync_err_reg;
        bus.drop_cnt    = drop_reg;
    end
endmodule

// File: tb/tb_symbol_deserializer.sv
// Bench for symbol_deserializer: directed scenarios plus random traffic, all
// outputs compared every cycle against a queue-based model of the block rules.
module tb_symbol_deserializer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    symbol_deserializer_if bus();
    symbol_deserializer dut (.clk(clk), .reset(reset), .bus(bus));

    localparam logic [127:0] PAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    int tests = 0;
    int fails = 0;
    int ovf_seen = 0;
    int serr_seen = 0;

    // Model: symbols of the partial block, buffered block, pulses, drops, deliveries.
    logic [1:0]   part_q[$];
    logic [127:0] m_cipher;
    bit           m_full;
    int           m_drops;
    bit           m_ovf, m_serr;
    logic [127:0] exp_deliv[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            part_q.delete();
            m_cipher = '0;
            m_full   = 1'b0;
            m_drops  = 0;
            m_ovf    = 1'b0;
            m_serr   = 1'b0;
        end else begin
            bit took, loaded;
            logic [127:0] blk;
            took   = m_full && bus.dec_ready;
            loaded = 1'b0;
            m_ovf  = 1'b0;
            m_serr = 1'b0;
            if (took) exp_deliv.push_back(m_cipher);
            if (bus.sym_valid) begin
                if (bus.sym_sof) begin
                    if (part_q.size() != 0) m_serr = 1'b1;
                    part_q.delete();
                    part_q.push_back(bus.sym_data);
                end else begin
                    part_q.push_back(bus.sym_data);
                    if (part_q.size() == 64) begin
                        blk = '0;
                        foreach (part_q[i]) blk = (blk << 2) | 128'(part_q[i]);
                        part_q.delete();
                        if (!m_full || took) begin
                            m_cipher = blk;
                            loaded   = 1'b1;
                        end else begin
                            m_ovf = 1'b1;
                            if (m_drops < 255) m_drops++;
                        end
                    end
                end
            end
            if (loaded) m_full = 1'b1;
            else if (took) m_full = 1'b0;
        end
    end

    always @(negedge clk) begin
        check("block_valid", 128'(bus.block_valid), 128'(m_full));
        check("cipher_data", bus.cipher_data, m_cipher);
        check("sym_cnt", 128'(bus.sym_cnt), 128'(part_q.size()));
        check("overflow", 128'(bus.overflow), 128'(m_ovf));
        check("sync_err", 128'(bus.sync_err), 128'(m_serr));
        check("drop_cnt", 128'(bus.drop_cnt), 128'(m_drops));
        if (bus.overflow) ovf_seen++;
        if (bus.sync_err) serr_seen++;
    end

    task automatic sym(input logic [1:0] d, input bit sof);
        @(posedge clk); #2;
        bus.sym_valid = 1'b1;
        bus.sym_data  = d;
        bus.sym_sof   = sof;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
            bus.sym_valid = 1'b0;
            bus.sym_sof   = 1'b0;
            bus.sym_data  = 2'($urandom);
        end
    endtask

    function automatic logic [1:0] nth(input logic [127:0] b, input int i);
        logic [127:0] t;
        t = b >> (126 - 2 * i);
        return t[1:0];
    endfunction

    task automatic block(input logic [127:0] b, input bit sof0);
        for (int i = 0; i < 64; i++) sym(nth(b, i), sof0 && i == 0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] a, b, c, d, e, f, g, h, j;
        int base, o0, s0;
        reset = 1'b0;
        bus.sym_valid = 1'b0;
        bus.sym_sof   = 1'b0;
        bus.sym_data  = 2'b00;
        bus.dec_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_block_valid", 128'(bus.block_valid), 128'd0);
        check("rst_cipher", bus.cipher_data, 128'd0);
        check("rst_drop_cnt", 128'(bus.drop_cnt), 128'd0);
        reset = 1'b1;

        // Single block, decryptor always ready.
        bus.dec_ready = 1'b1;
        base = exp_deliv.size();
        block(PAT, 1'b0);
        idle(4);
        check("single_count", 128'(exp_deliv.size() - base), 128'd1);
        check("single_value", exp_deliv[base], PAT);

        // Back-to-back: ready only from the second block's 32nd symbol.
        bus.dec_ready = 1'b0;
        a = rnd128(); b = rnd128();
        base = exp_deliv.size();
        block(a, 1'b1);
        for (int i = 0; i < 64; i++) begin
            sym(nth(b, i), 1'b0);
            if (i == 31) bus.dec_ready = 1'b1;
        end
        idle(4);
        check("b2b_count", 128'(exp_deliv.size() - base), 128'd2);
        check("b2b_first", exp_deliv[base], a);
        check("b2b_second", exp_deliv[base + 1], b);
        check("b2b_drops", 128'(bus.drop_cnt), 128'd0);

        // Overflow: three blocks with the decryptor stalled.
        bus.dec_ready = 1'b0;
        c = rnd128(); d = rnd128(); e = rnd128();
        o0 = ovf_seen;
        base = exp_deliv.size();
        block(c, 1'b0); block(d, 1'b0); block(e, 1'b0);
        idle(2);
        check("ovf_held", bus.cipher_data, c);
        check("ovf_pulses", 128'(ovf_seen - o0), 128'd2);
        check("ovf_drop_cnt", 128'(bus.drop_cnt), 128'd2);
        bus.dec_ready = 1'b1;
        idle(4);
        check("ovf_count", 128'(exp_deliv.size() - base), 128'd1);
        check("ovf_value", exp_deliv[base], c);

        // Simultaneous accept of block 1 and completion of block 2.
        bus.dec_ready = 1'b0;
        f = rnd128(); g = rnd128();
        base = exp_deliv.size();
        block(f, 1'b0);
        for (int i = 0; i < 64; i++) begin
            sym(nth(g, i), 1'b0);
            bus.dec_ready = (i == 63);
        end
        idle(1);
        check("simul_still_valid", 128'(bus.block_valid), 128'd1);
        check("simul_new_data", bus.cipher_data, g);
        bus.dec_ready = 1'b1;
        idle(3);
        check("simul_count", 128'(exp_deliv.size() - base), 128'd2);
        check("simul_first", exp_deliv[base], f);
        check("simul_second", exp_deliv[base + 1], g);

        // Resync: SOF on the 20th symbol restarts the block.
        h = rnd128();
        s0 = serr_seen;
        base = exp_deliv.size();
        for (int i = 0; i < 19; i++) sym(2'($urandom), 1'b0);
        sym(nth(h, 0), 1'b1);
        sym(nth(h, 1), 1'b0);
        check("resync_cnt", 128'(bus.sym_cnt), 128'd1);
        for (int i = 2; i < 64; i++) sym(nth(h, i), 1'b0);
        idle(3);
        check("resync_pulses", 128'(serr_seen - s0), 128'd1);
        check("resync_count", 128'(exp_deliv.size() - base), 128'd1);
        check("resync_value", exp_deliv[base], h);

        // Asynchronous reset with a full buffer and 40 symbols pending.
        bus.dec_ready = 1'b0;
        block(rnd128(), 1'b0);
        for (int i = 0; i < 40; i++) sym(2'($urandom), 1'b0);
        @(posedge clk); #3;
        check("pre_rst_cnt", 128'(bus.sym_cnt), 128'd40);
        reset = 1'b0;
        #1;
        check("async_block_valid", 128'(bus.block_valid), 128'd0);
        check("async_sym_cnt", 128'(bus.sym_cnt), 128'd0);
        check("async_cipher", bus.cipher_data, 128'd0);
        check("async_drop_cnt", 128'(bus.drop_cnt), 128'd0);
        bus.sym_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        bus.dec_ready = 1'b1;
        j = rnd128();
        base = exp_deliv.size();
        block(j, 1'b0);
        idle(3);
        check("post_rst_count", 128'(exp_deliv.size() - base), 128'd1);
        check("post_rst_value", exp_deliv[base], j);

        // Random traffic: gaps, occasional SOF, bursty decryptor readiness.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            bus.sym_valid = ($urandom_range(0, 9) != 0);
            bus.sym_sof   = ($urandom_range(0, 149) == 0);
            bus.sym_data  = 2'($urandom);
            if (i % 64 == 0) bus.dec_ready = ($urandom_range(0, 2) != 0);
            else if ($urandom_range(0, 7) == 0) bus.dec_ready = ~bus.dec_ready;
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
